// File: rtl/cdc_pkg.sv
// Shared types and helpers for CDC status/filter blocks.
package cdc_pkg;

  typedef enum logic {
    STABLE  = 1'b0,
    QUALIFY = 1'b1
  } dbnc_state_e;

  // Counter width able to hold 0..stable_cycles.
  function automatic int unsigned calc_cnt_w(input int unsigned stable_cycles);
    return $clog2(stable_cycles + 1);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear that wins over increment.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_inc,
  input  logic         i_clr,
  output logic [W-1:0] o_cnt
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (i_clr) begin
      cnt_d = '0;
    end else if (i_inc && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign o_cnt = cnt_q;

endmodule

// File: rtl/sync_level_debouncer.sv
// Level debouncer for an already-synchronized bit: a new level is accepted only
// after STABLE_CYCLES consecutive differing samples; emits edge pulses and a count.
module sync_level_debouncer
  import cdc_pkg::*;
#(
  parameter int   STABLE_CYCLES = 4,
  parameter int   EVT_CNT_W     = 8,
  parameter logic RST_LEVEL     = 1'b0
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_en,
  input  logic                 i_level,
  input  logic                 i_clr_cnt,
  output logic                 o_level,
  output logic                 o_rise,
  output logic                 o_fall,
  output logic                 o_busy,
  output logic [EVT_CNT_W-1:0] o_evt_cnt
);

  localparam int CNT_W = calc_cnt_w(STABLE_CYCLES);

  if ((STABLE_CYCLES < 1) || (STABLE_CYCLES > 65535)) begin : g_bad_param
    $error("sync_level_debouncer: STABLE_CYCLES must be in 1..65535");
  end

  dbnc_state_e      state_q, state_d;
  logic [CNT_W-1:0] qual_cnt_q, qual_cnt_d;
  logic             level_q, level_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;
  logic             busy_q, busy_d;
  logic             diff;
  logic             flip;

  assign diff = (i_level != level_q);

  always_comb begin
    state_d    = state_q;
    qual_cnt_d = qual_cnt_q;
    flip       = 1'b0;

    if (!i_en) begin
      state_d    = STABLE;
      qual_cnt_d = '0;
    end else begin
      case (state_q)
        STABLE: begin
          if (diff) begin
            if (STABLE_CYCLES == 1) begin
              flip = 1'b1;
            end else begin
              qual_cnt_d = CNT_W'(1);
              state_d    = QUALIFY;
            end
          end
        end
        QUALIFY: begin
          if (!diff) begin
            // Input fell back before qualifying: treat as a glitch.
            qual_cnt_d = '0;
            state_d    = STABLE;
          end else if (qual_cnt_q == CNT_W'(STABLE_CYCLES - 1)) begin
            flip       = 1'b1;
            qual_cnt_d = '0;
            state_d    = STABLE;
          end else begin
            qual_cnt_d = qual_cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_d    = STABLE;
          qual_cnt_d = '0;
        end
      endcase
    end

    level_d = flip ? ~level_q : level_q;
    rise_d  = flip & ~level_q;
    fall_d  = flip &  level_q;
    busy_d  = (state_d == QUALIFY);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= STABLE;
      qual_cnt_q <= '0;
      level_q    <= RST_LEVEL;
      rise_q     <= 1'b0;
      fall_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      qual_cnt_q <= qual_cnt_d;
      level_q    <= level_d;
      rise_q     <= rise_d;
      fall_q     <= fall_d;
      busy_q     <= busy_d;
    end
  end

  sat_counter #(
    .W (EVT_CNT_W)
  ) u_evt_cnt (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_inc   (flip),
    .i_clr   (i_clr_cnt),
    .o_cnt   (o_evt_cnt)
  );

  assign o_level = level_q;
  assign o_rise  = rise_q;
  assign o_fall  = fall_q;
  assign o_busy  = busy_q;

endmodule

// File: tb/tb_sync_level_debouncer.sv
// Directed bench: one debouncer with STABLE_CYCLES=4 and a 2-bit event counter,
// one with STABLE_CYCLES=1 for the back-to-back toggle case.
module tb_sync_level_debouncer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en_a, lvl_a, clr_a;
  logic       en_b, lvl_b, clr_b;
  logic       a_level, a_rise, a_fall, a_busy;
  logic [1:0] a_evt;
  logic       b_level, b_rise, b_fall, b_busy;
  logic [7:0] b_evt;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  sync_level_debouncer #(
    .STABLE_CYCLES (4),
    .EVT_CNT_W     (2),
    .RST_LEVEL     (1'b0)
  ) u_dut_a (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_en      (en_a),
    .i_level   (lvl_a),
    .i_clr_cnt (clr_a),
    .o_level   (a_level),
    .o_rise    (a_rise),
    .o_fall    (a_fall),
    .o_busy    (a_busy),
    .o_evt_cnt (a_evt)
  );

  sync_level_debouncer #(
    .STABLE_CYCLES (1),
    .EVT_CNT_W     (8),
    .RST_LEVEL     (1'b0)
  ) u_dut_b (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_en      (en_b),
    .i_level   (lvl_b),
    .i_clr_cnt (clr_b),
    .o_level   (b_level),
    .o_rise    (b_rise),
    .o_fall    (b_fall),
    .o_busy    (b_busy),
    .o_evt_cnt (b_evt)
  );

  always @(posedge clk) begin
    if (rst_n) begin
      assert (!$isunknown(lvl_a) && !$isunknown(lvl_b))
        else $error("i_level unknown while out of reset");
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
      else begin
        n_errors++;
        $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
  endtask

  // Hold v for four samples; optionally pulse clr on the accepting edge.
  task automatic a_accept(input logic v, input logic clr_last, input string tag);
    lvl_a = v;
    for (int i = 0; i < 3; i++) begin
      step();
      chk({tag, "_busy"}, a_busy, 1);
      chk({tag, "_hold"}, a_level, !v);
    end
    clr_a = clr_last;
    step();
    clr_a = 1'b0;
    chk({tag, "_level"}, a_level, v);
    chk({tag, "_rise"}, a_rise, v);
    chk({tag, "_fall"}, a_fall, !v);
    chk({tag, "_busy_done"}, a_busy, 0);
  endtask

  initial begin
    logic [1:0] sat_exp [5];
    sat_exp[0] = 2'd1; sat_exp[1] = 2'd2; sat_exp[2] = 2'd3;
    sat_exp[3] = 2'd3; sat_exp[4] = 2'd3;

    rst_n = 1'b0;
    en_a  = 1'b1; lvl_a = 1'b0; clr_a = 1'b0;
    en_b  = 1'b1; lvl_b = 1'b0; clr_b = 1'b0;
    step();
    step();
    chk("rst_level", a_level, 0);
    chk("rst_rise",  a_rise, 0);
    chk("rst_fall",  a_fall, 0);
    chk("rst_busy",  a_busy, 0);
    chk("rst_evt",   a_evt, 0);
    chk("rst_b_level", b_level, 0);
    rst_n = 1'b1;
    step();
    chk("idle_busy", a_busy, 0);

    // Glitch: three samples of 1 then back to 0.
    lvl_a = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("glitch_busy", a_busy, 1);
      chk("glitch_rise", a_rise, 0);
    end
    lvl_a = 1'b0;
    step();
    chk("glitch_busy_drop", a_busy, 0);
    chk("glitch_level", a_level, 0);
    chk("glitch_rise_end", a_rise, 0);
    chk("glitch_evt", a_evt, 0);

    // Clean rise.
    a_accept(1'b1, 1'b0, "rise");
    chk("rise_evt", a_evt, 1);
    step();
    chk("rise_pulse_once", a_rise, 0);
    chk("rise_level_held", a_level, 1);

    // Standalone clear.
    clr_a = 1'b1;
    step();
    clr_a = 1'b0;
    chk("clr_alone", a_evt, 0);

    // Five transitions ending 1->0 with a 2-bit saturating counter.
    for (int k = 0; k < 5; k++) begin
      a_accept(k[0] ? 1'b1 : 1'b0, 1'b0, "sat");
      chk("sat_evt", a_evt, sat_exp[k]);
    end
    step();
    chk("sat_fall_once", a_fall, 0);
    chk("sat_level", a_level, 0);

    // Clear on the accepting edge: count zeroed, level and pulse still happen.
    a_accept(1'b1, 1'b1, "clrpri");
    chk("clrpri_evt", a_evt, 0);

    // Drop enable with qual_cnt=2, then re-enable.
    lvl_a = 1'b0;
    step();
    step();
    chk("en_busy_before", a_busy, 1);
    en_a = 1'b0;
    step();
    chk("en_off_busy", a_busy, 0);
    chk("en_off_level", a_level, 1);
    step();
    chk("en_off_level2", a_level, 1);
    chk("en_off_fall", a_fall, 0);
    en_a = 1'b1;
    a_accept(1'b0, 1'b0, "reen");
    chk("reen_evt", a_evt, 1);

    // Asynchronous reset in the middle of a qualification.
    lvl_a = 1'b1;
    step();
    step();
    chk("abort_busy_before", a_busy, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_busy", a_busy, 0);
    chk("abort_level", a_level, 0);
    chk("abort_evt", a_evt, 0);
    chk("abort_rise", a_rise, 0);
    lvl_a = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    chk("abort_after_level", a_level, 0);
    chk("abort_after_rise", a_rise, 0);

    // STABLE_CYCLES=1: follows every toggle one cycle later.
    for (int k = 0; k < 4; k++) begin
      lvl_b = ~lvl_b;
      step();
      chk("t1_level", b_level, lvl_b);
      chk("t1_rise", b_rise, lvl_b);
      chk("t1_fall", b_fall, !lvl_b);
      chk("t1_busy", b_busy, 0);
      chk("t1_evt", b_evt, k + 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
